snn_image_uart_tx: RTL
======================

Name: snn_image_uart_tx

Overview:
Host-link transmitter for the SNN image path. It is the reverse of the receive/unpack path that fills the 1-bit image RAM from UART. On start, it reads the 784-pixel (28x28) image out of a 1-bit-wide RAM, packs 8 pixels per byte, and serializes 98 bytes as back-to-back 8N1 UART frames. It is used for image readback/loopback checks and as the sending end in host-emulation benches.

Parameters:
BAUD_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..4095
NUM_BYTES, 98, bytes per image (pixels = 8*NUM_BYTES); legal range 1..127
ADDR_W, 10, image RAM address width

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin transfer; sampled only in IDLE
mem_addr  out  ADDR_W  image RAM read address
mem_q  in  1  image RAM read data; valid one cycle after mem_addr
tx  out  1  UART serial output; idles high
busy  out  1  high while a transfer is in progress
done  out  1  one-cycle pulse when the last stop bit completes
byte_cnt  out  7  number of frames fully transmitted in the current/last transfer

Behaviour:
- Reset (async, any state): tx=1, busy=0, done=0, mem_addr=0, byte_cnt=0, FSM=IDLE, all shift/prefetch registers cleared. Reset mid-frame truncates the frame; tx returns high immediately.
- Packing: byte k, bit j (j=0 LSB) = pixel at address 8k+j. Serial order is LSB first.
- Frame format: start bit (0), d0..d7, stop bit (1). Each bit is held exactly BAUD_DIV cycles, so a frame is 10*BAUD_DIV cycles.
- FSM states:
  - IDLE: start=1 at edge T is accepted. busy=1 and byte_cnt=0 from T+1. start is ignored while busy=1.
  - PREFETCH: cycles T+1..T+8 drive mem_addr=0..7. mem_q is captured at T+2..T+9 into a pack register, bit by bit.
  - SEND: tx=0 (start bit of byte 0) from cycle T+10. While frame k shifts out, the fetcher reads addresses 8(k+1)..8(k+1)+7 into a shadow register. The fetch (9 cycles) is always shorter than a frame because BAUD_DIV>=2, so the shadow register is ready before the frame ends.
  - Frame k+1 start bit begins the cycle immediately after frame k stop bit ends: no idle gap between frames. No fetch is issued beyond address 8*NUM_BYTES-1.
  - byte_cnt increments on the last cycle of each stop bit.
  - FINISH: in the cycle after the final stop bit, done=1 for one cycle, busy=0, FSM returns to IDLE. tx=1, and mem_addr holds its last value.
- Total transfer time: start edge to done pulse = 10 + NUM_BYTES*10*BAUD_DIV cycles.
- start=1 in the same cycle done=1 is accepted, since the FSM is in IDLE; a new transfer begins.
- Baud counter: counts 0..BAUD_DIV-1 and wraps. A bit index of 0..9 advances on each wrap. Both reset to 0 at the start of every frame.
- Width rules: byte_cnt saturates at NUM_BYTES. The address counter is ADDR_W bits wide and never wraps within a transfer.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> same cycle tx=1, busy=0, done=0, mem_addr=0, byte_cnt=0.
- Single byte, BAUD_DIV=4, NUM_BYTES=1, pixels 0..7 = 1,0,1,0,0,0,0,0 -> mem_addr 0..7 on T+1..T+8. tx=0 on T+10..T+13, then data bits 1,0,1,0,0,0,0,0 each 4 cycles, then stop=1. done pulses at T+50, byte_cnt=1.
- Full image, BAUD_DIV=4, pixel 8k+j = bit j of k -> UART monitor decodes 0x00..0x61 in order with no inter-frame gap. done pulses exactly once at T+3930; byte_cnt=98.
- start held high throughout a transfer -> exactly one transfer. start pulsed again in the done cycle -> second transfer restarts at mem_addr=0, byte_cnt clears to 0.
- Reset asserted during the data bits of byte 50 -> tx=1 at once, busy=0. A later start sends byte 0 first, and the bytes decode correctly.
- BAUD_DIV=2 (minimum) with an all-ones image -> 98 frames of 0xFF. The shadow register is never late: each start bit falls exactly 20 cycles after the previous one.

Source files
------------

// File: rtl/snn_image_uart_tx_if.sv
`default_nettype none
// ============================================================================
// snn_image_uart_tx_if : image RAM read port, UART line and transfer status
// Rev 1.0
// ============================================================================
interface snn_image_uart_tx_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_q;
  logic              tx;
  logic              busy;
  logic              done;
  logic [6:0]        byte_cnt;

  modport master (
    input  start, mem_q,
    output mem_addr, tx, busy, done, byte_cnt
  );

  modport slave (
    output start, mem_q,
    input  mem_addr, tx, busy, done, byte_cnt
  );
endinterface
`default_nettype wire

// File: rtl/snn_image_uart_tx.sv
`default_nettype none
// ============================================================================
// snn_image_uart_tx : reads a 1-bit image RAM, packs 8 pixels/byte (LSB =
// lowest address) and sends the bytes as back-to-back 8N1 UART frames.
// Rev 1.0
// ============================================================================
module snn_image_uart_tx #(
  parameter int BAUD_DIV  = 434,
  parameter int NUM_BYTES = 98,
  parameter int ADDR_W    = 10
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  snn_image_uart_tx_if.master bus
);
  localparam logic [11:0]       BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [6:0]        N_BYTES   = 7'(NUM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    SEND     = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              issue_v;
  logic [2:0]        issue_bit;
  logic              cap_v;
  logic [2:0]        cap_bit;
  logic [6:0]        fetch_cnt;
  logic [7:0]        pack;
  logic [8:0]        shift;
  logic [11:0]       baud_cnt;
  logic [3:0]        bit_idx;
  logic              tx_r;
  logic              busy_r;
  logic              done_r;
  logic [6:0]        cnt;
  logic [6:0]        cnt_nxt;
  logic              fetch_more;

  assign cnt_nxt    = (cnt == N_BYTES) ? cnt : cnt + 7'd1;
  assign fetch_more = (fetch_cnt < N_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      issue_v   <= 1'b0;
      issue_bit <= 3'd0;
      cap_v     <= 1'b0;
      cap_bit   <= 3'd0;
      fetch_cnt <= 7'd0;
      pack      <= 8'd0;
      shift     <= 9'd0;
      baud_cnt  <= 12'd0;
      bit_idx   <= 4'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cnt       <= 7'd0;
    end else begin
      done_r  <= 1'b0;
      // Fetcher: address issued in one cycle, mem_q captured the next
      cap_v   <= issue_v;
      cap_bit <= issue_bit;
      if (cap_v) pack[cap_bit] <= bus.mem_q;
      if (issue_v) begin
        if (issue_bit == 3'd7) begin
          issue_v <= 1'b0;
        end else begin
          issue_bit <= issue_bit + 3'd1;
          addr      <= addr + ADDR_ONE;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= PREFETCH;
            busy_r    <= 1'b1;
            cnt       <= 7'd0;
            addr      <= '0;
            issue_v   <= 1'b1;
            issue_bit <= 3'd0;
            fetch_cnt <= 7'd1;
          end
        end

        PREFETCH: begin
          // Bit 7 arrives this cycle, so it bypasses the pack register
          if (cap_v && cap_bit == 3'd7) begin
            state    <= SEND;
            shift    <= {1'b1, bus.mem_q, pack[6:0]};
            tx_r     <= 1'b0;
            baud_cnt <= 12'd0;
            bit_idx  <= 4'd0;
            if (fetch_more) begin
              issue_v   <= 1'b1;
              issue_bit <= 3'd0;
              addr      <= addr + ADDR_ONE;
              fetch_cnt <= fetch_cnt + 7'd1;
            end
          end
        end

        SEND: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= 12'd0;
            if (bit_idx == 4'd9) begin
              cnt <= cnt_nxt;
              if (cnt_nxt >= N_BYTES) begin
                state  <= IDLE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
                tx_r   <= 1'b1;
              end else begin
                // Shadow byte was fetched during the frame just sent
                shift   <= {1'b1, pack};
                tx_r    <= 1'b0;
                bit_idx <= 4'd0;
                if (fetch_more) begin
                  issue_v   <= 1'b1;
                  issue_bit <= 3'd0;
                  addr      <= addr + ADDR_ONE;
                  fetch_cnt <= fetch_cnt + 7'd1;
                end
              end
            end else begin
              tx_r    <= shift[0];
              shift   <= {1'b0, shift[8:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr = addr;
  assign bus.tx       = tx_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.byte_cnt = cnt;

endmodule
`default_nettype wire
